logic_unit_arbiter: RTL

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a registered logic unit.
// Each operation takes one IDLE grant, one ISSUE and one WAIT cycle, then waits in RESP until it is consumed.
module logic_unit_arbiter #(
  parameter logic [1:0] FUN_HI = 2'b01
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req0_fun,
  input  logic [1:0]  req1_fun,
  output logic [15:0] lu_a,
  output logic [15:0] lu_b,
  output logic [3:0]  lu_fun,
  output logic        lu_en,
  input  logic [15:0] lu_out,
  input  logic        lu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       grant;
  logic       grant_id;
  logic       last_served;
  logic [1:0] lat_fun;
  logic       lat_id;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // reqN_ready is only offered in IDLE and depends on the valids, never on the other ready.
  // rsp_valid stays high with stable payload until rsp_ready is seen.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!RST && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          grant_id   = (req0_valid && req1_valid) ? ~last_served : req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand registers double as the logic-unit drive, so they hold when idle.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lu_a        <= 16'h0000;
      lu_b        <= 16'h0000;
      lat_fun     <= 2'b00;
      lat_id      <= 1'b0;
      last_served <= 1'b1;
      rsp_data    <= 16'h0000;
      rsp_id      <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      if (grant) begin
        lu_a    <= grant_id ? req1_a : req0_a;
        lu_b    <= grant_id ? req1_b : req0_b;
        lat_fun <= grant_id ? req1_fun : req0_fun;
        lat_id  <= grant_id;
      end
      if (state == WAIT) begin
        rsp_data <= lu_out;
        rsp_err  <= ~lu_flag;
        rsp_id   <= lat_id;
      end
      if (state == RESP && rsp_ready) last_served <= rsp_id;
    end
  end

  assign lu_fun    = {FUN_HI, lat_fun};
  assign lu_en     = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign state_dbg = state;

endmodule
